mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multicycle control unit that sits directly upstream of the register file.
- Sequences every instruction through IF/ID/EXE/MEM/WB states and decodes the instruction-register opcode.
- Drives the register-file write enable and write-destination select, plus PC, IR, ALU and data-memory controls.
- One instance per CPU, in the datapath top.

Parameters:
- OPW, 6, opcode width
- RA_IDX, 31, register index written by jal

Ports:
- CLK  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Op  in  OPW  opcode from instruction register (IR[31:26]), stable from ID onward
- Zero  in  1  ALU zero flag
- PCWre  out  1  PC load enable
- IRWre  out  1  instruction register load enable
- RegWre  out  1  register-file write enable (sampled by the register file on CLK negedge)
- RegDst  out  2  write register select: 00=$31, 01=rt, 10=rd
- WrRegDSrc  out  1  write data source: 0=PC+4, 1=DB bus
- DBDataSrc  out  1  DB bus source: 0=ALU result, 1=memory read data
- ALUSrcB  out  1  ALU B operand: 0=register, 1=extended immediate
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 and, 100 slt
- ExtSel  out  1  0=zero-extend, 1=sign-extend
- mRD  out  1  data memory read
- mWR  out  1  data memory write
- PCSrc  out  2  00=PC+4, 01=branch target, 10=rs (jr), 11=jump target
- State  out  4  current state encoding, for debug and verification
- Illegal  out  1  set when an undefined opcode is decoded

Behaviour:
- Opcodes, fixed:
  - add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, slt 100110
  - sw 110000, lw 110001, beq 110100
  - j 111000, jr 111001, jal 111010, halt 111111
- States, a single registered state variable:
  - IF=0, ID=1, EXE_AL=2, WB_AL=3, EXE_BR=4, EXE_LS=5, MEM=6, WB_LD=7, HALT=8
- Transitions:
  - IF->ID, always.
  - ID: j/jr/jal -> IF; beq -> EXE_BR; lw/sw -> EXE_LS; halt -> HALT; defined ALU ops -> EXE_AL; undefined -> HALT with Illegal=1.
  - EXE_AL->WB_AL->IF.
  - EXE_BR->IF.
  - EXE_LS->MEM.
  - MEM: lw -> WB_LD; sw -> IF.
  - WB_LD->IF.
  - HALT holds until Reset.
- Outputs are combinational from (state, Op, Zero). Unlisted outputs are 0.
  - IF: IRWre=1.
  - ID for j/jr/jal: PCWre=1; PCSrc=11 (j, jal) or 10 (jr).
    - jal in ID also drives RegWre=1, RegDst=00, WrRegDSrc=0. The link write is done in ID.
  - EXE_AL: ALUOp per opcode. ALUSrcB=1 for addi/ori. ExtSel=1 for addi, 0 for ori.
  - WB_AL: same ALU controls as EXE_AL, plus RegWre=1, WrRegDSrc=1, DBDataSrc=0, RegDst=01 for immediates or 10 for R-type, PCWre=1, PCSrc=00.
  - EXE_BR: ALUOp=001, PCWre=1, PCSrc = Zero ? 01 : 00, ExtSel=1.
  - EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1.
  - MEM:
    - lw: mRD=1.
    - sw: mWR=1, PCWre=1, PCSrc=00.
  - WB_LD: mRD=1, DBDataSrc=1, WrRegDSrc=1, RegDst=01, RegWre=1, PCWre=1, PCSrc=00.
  - HALT: every enable is 0.
- Exactly one PCWre pulse per instruction, asserted in its final state. The PC updates on the CLK posedge leaving that state.
- RegWre is held for the entire WB/ID cycle, so the register file's negedge write sees stable RegDst and data.
- Illegal is a sticky register: set on the ID->HALT transition for undefined opcodes, cleared only by Reset.
- Reset:
  - On a posedge with Reset=1, State<=IF and Illegal<=0, at any time including mid-instruction.
  - While Reset=1, PCWre, IRWre, RegWre and mWR are forced to 0 combinationally.
  - Fetch begins on the first cycle after Reset deasserts.
- Op changes outside ID are ignored for state transitions. Op is assumed stable from ID through the instruction's final state.

Decomposition:
- Shared package mc_defs:
  - opcode constants
  - state encodings
  - ALUOp, RegDst and PCSrc codes
  - These are reused by the ALU, the PC mux and the testbenches.
- Optional sub-module mc_ctrl_decode: the purely combinational output decode from (state, Op, Zero). The FSM register and next-state logic stay in mc_ctrl_fsm.

Test Plan:
- add (Op=000000) after Reset: State sequence 0,1,2,3,0.
  - RegWre=1 only in state 3, with RegDst=10, WrRegDSrc=1.
  - PCWre=1 only in state 3.
- lw (110001): sequence 0,1,5,6,7,0; mRD=1 in 6 and 7; RegWre=1 in 7 with RegDst=01, DBDataSrc=1.
- sw (110000): sequence 0,1,5,6,0; mWR=1 only in 6; RegWre never asserted.
- beq (110100) with Zero=1: PCSrc=01 in state 4. Repeat with Zero=0: PCSrc=00. Both give a 3-cycle instruction.
- jal (111010): 2-cycle instruction; in ID, RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
- Op=101010 (undefined): HALT reached, Illegal=1, all enables 0 for 20 cycles.
  - Then Reset=1 for one cycle mid-sequence: State=0 and Illegal=0 next cycle; PCWre, IRWre, RegWre and mWR are 0 while Reset is high.

Source files
------------

// File: rtl/mc_defs.sv
// Shared control definitions for the multicycle CPU: opcodes, states,
// datapath select codes and opcode classification helpers.
package mc_defs;

   typedef logic [5:0] op_t;

   localparam op_t OP_ADD  = 6'b000000;
   localparam op_t OP_SUB  = 6'b000001;
   localparam op_t OP_ADDI = 6'b000010;
   localparam op_t OP_OR   = 6'b010000;
   localparam op_t OP_AND  = 6'b010001;
   localparam op_t OP_ORI  = 6'b010010;
   localparam op_t OP_SLT  = 6'b100110;
   localparam op_t OP_SW   = 6'b110000;
   localparam op_t OP_LW   = 6'b110001;
   localparam op_t OP_BEQ  = 6'b110100;
   localparam op_t OP_J    = 6'b111000;
   localparam op_t OP_JR   = 6'b111001;
   localparam op_t OP_JAL  = 6'b111010;
   localparam op_t OP_HALT = 6'b111111;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_EXE_AL = 4'd2,
      S_WB_AL  = 4'd3,
      S_EXE_BR = 4'd4,
      S_EXE_LS = 4'd5,
      S_MEM    = 4'd6,
      S_WB_LD  = 4'd7,
      S_HALT   = 4'd8
   } state_e;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   localparam logic [1:0] RD_RA = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RD = 2'b10;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JR  = 2'b10;
   localparam logic [1:0] PC_JMP = 2'b11;

   typedef struct packed {
      logic       pcwre;
      logic       irwre;
      logic       regwre;
      logic [1:0] regdst;
      logic       wrregdsrc;
      logic       dbdatasrc;
      logic       alusrcb;
      logic [2:0] aluop;
      logic       extsel;
      logic       mrd;
      logic       mwr;
      logic [1:0] pcsrc;
   } ctrl_t;

   function automatic logic is_alu_op(input op_t op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDI, OP_OR,
         OP_AND, OP_ORI, OP_SLT: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

   function automatic logic is_jump(input op_t op);
      return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
   endfunction

   function automatic logic is_imm(input op_t op);
      return (op == OP_ADDI) || (op == OP_ORI);
   endfunction

   function automatic logic [2:0] alu_op_of(input op_t op);
      case (op)
         OP_SUB:         return ALU_SUB;
         OP_OR, OP_ORI:  return ALU_OR;
         OP_AND:         return ALU_AND;
         OP_SLT:         return ALU_SLT;
         default:        return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode from current state, opcode and ALU zero.
// Holds no state; the FSM register lives in mc_ctrl_fsm.
module mc_ctrl_decode
   import mc_defs::*;
(
   input  state_e state_i,
   input  op_t    op_i,
   input  logic   zero_i,
   output ctrl_t  ctrl_o
);

   ctrl_t c;

   always_comb begin
      c = '0;
      unique case (state_i)
         S_IF: c.irwre = 1'b1;
         S_ID: begin
            if (is_jump(op_i)) begin
               c.pcwre = 1'b1;
               c.pcsrc = (op_i == OP_JR) ? PC_JR : PC_JMP;
               // Link is written here since jal has no WB state.
               if (op_i == OP_JAL) begin
                  c.regwre    = 1'b1;
                  c.regdst    = RD_RA;
                  c.wrregdsrc = 1'b0;
               end
            end
         end
         S_EXE_AL, S_WB_AL: begin
            c.aluop   = alu_op_of(op_i);
            c.alusrcb = is_imm(op_i);
            c.extsel  = (op_i == OP_ADDI);
            if (state_i == S_WB_AL) begin
               c.regwre    = 1'b1;
               c.wrregdsrc = 1'b1;
               c.dbdatasrc = 1'b0;
               c.regdst    = is_imm(op_i) ? RD_RT : RD_RD;
               c.pcwre     = 1'b1;
               c.pcsrc     = PC_SEQ;
            end
         end
         S_EXE_BR: begin
            c.aluop  = ALU_SUB;
            c.pcwre  = 1'b1;
            c.pcsrc  = zero_i ? PC_BR : PC_SEQ;
            c.extsel = 1'b1;
         end
         S_EXE_LS: begin
            c.aluop   = ALU_ADD;
            c.alusrcb = 1'b1;
            c.extsel  = 1'b1;
         end
         S_MEM: begin
            if (op_i == OP_LW) begin
               c.mrd = 1'b1;
            end else if (op_i == OP_SW) begin
               c.mwr   = 1'b1;
               c.pcwre = 1'b1;
               c.pcsrc = PC_SEQ;
            end
         end
         S_WB_LD: begin
            c.mrd       = 1'b1;
            c.dbdatasrc = 1'b1;
            c.wrregdsrc = 1'b1;
            c.regdst    = RD_RT;
            c.regwre    = 1'b1;
            c.pcwre     = 1'b1;
            c.pcsrc     = PC_SEQ;
         end
         default: c = '0;
      endcase
   end

   assign ctrl_o = c;

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control FSM: sequences IF/ID/EXE/MEM/WB, tracks illegal
// opcodes and drives the datapath controls through mc_ctrl_decode.
module mc_ctrl_fsm
   import mc_defs::*;
#(
   parameter int OPW    = 6,
   parameter int RA_IDX = 31
) (
   input  logic           CLK,
   input  logic           Reset,
   input  logic [OPW-1:0] Op,
   input  logic           Zero,
   output logic           PCWre,
   output logic           IRWre,
   output logic           RegWre,
   output logic [1:0]     RegDst,
   output logic           WrRegDSrc,
   output logic           DBDataSrc,
   output logic           ALUSrcB,
   output logic [2:0]     ALUOp,
   output logic           ExtSel,
   output logic           mRD,
   output logic           mWR,
   output logic [1:0]     PCSrc,
   output logic [3:0]     State,
   output logic           Illegal
);

   // RegDst=00 hard-selects $31 and opcodes are fixed 6-bit codes.
   if (OPW != 6) begin : g_opw_chk
      $error("mc_ctrl_fsm: OPW must be 6");
   end
   if (RA_IDX != 31) begin : g_ra_chk
      $error("mc_ctrl_fsm: RA_IDX must be 31");
   end

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;
   ctrl_t  ctrl;
   op_t    op;

   assign op = Op;

   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      unique case (state_q)
         S_IF: state_d = S_ID;
         S_ID: begin
            unique case (1'b1)
               is_jump(op):               state_d = S_IF;
               op == OP_BEQ:              state_d = S_EXE_BR;
               op == OP_LW, op == OP_SW:  state_d = S_EXE_LS;
               op == OP_HALT:             state_d = S_HALT;
               is_alu_op(op):             state_d = S_EXE_AL;
               default: begin
                  state_d   = S_HALT;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_WB_AL:  state_d = S_IF;
         S_EXE_BR: state_d = S_IF;
         S_EXE_LS: state_d = S_MEM;
         S_MEM:    state_d = (op == OP_LW) ? S_WB_LD : S_IF;
         S_WB_LD:  state_d = S_IF;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_IF;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q   <= S_IF;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   mc_ctrl_decode u_decode (
      .state_i (state_q),
      .op_i    (op),
      .zero_i  (Zero),
      .ctrl_o  (ctrl)
   );

   // Write/load enables are gated so a reset pulse can never commit state.
   assign PCWre     = ctrl.pcwre  & ~Reset;
   assign IRWre     = ctrl.irwre  & ~Reset;
   assign RegWre    = ctrl.regwre & ~Reset;
   assign mWR       = ctrl.mwr    & ~Reset;
   assign RegDst    = ctrl.regdst;
   assign WrRegDSrc = ctrl.wrregdsrc;
   assign DBDataSrc = ctrl.dbdatasrc;
   assign ALUSrcB   = ctrl.alusrcb;
   assign ALUOp     = ctrl.aluop;
   assign ExtSel    = ctrl.extsel;
   assign mRD       = ctrl.mrd;
   assign PCSrc     = ctrl.pcsrc;
   assign State     = state_q;
   assign Illegal   = illegal_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: walks each instruction class through
// its state sequence and checks the control outputs cycle by cycle.
module tb_mc_ctrl_fsm;

   logic       CLK = 1'b0;
   logic       Reset = 1'b1;
   logic [5:0] Op = 6'b000000;
   logic       Zero = 1'b0;
   logic       PCWre, IRWre, RegWre, WrRegDSrc, DBDataSrc;
   logic       ALUSrcB, ExtSel, mRD, mWR, Illegal;
   logic [1:0] RegDst, PCSrc;
   logic [2:0] ALUOp;
   logic [3:0] State;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   mc_ctrl_fsm #(.OPW(6), .RA_IDX(31)) dut (
      .CLK(CLK), .Reset(Reset), .Op(Op), .Zero(Zero),
      .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre),
      .RegDst(RegDst), .WrRegDSrc(WrRegDSrc), .DBDataSrc(DBDataSrc),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtSel(ExtSel),
      .mRD(mRD), .mWR(mWR), .PCSrc(PCSrc), .State(State),
      .Illegal(Illegal)
   );

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      cyc();
      Reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      Op = 6'b000000;
      Reset = 1'b1;
      cyc();
      n_cmp++;
      if (State !== 4'd0 || Illegal !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_state: got st=%0d ill=%b want st=0 ill=0",
                  State, Illegal);
      end
      n_cmp++;
      if ({PCWre, IRWre, RegWre, mWR} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_gate: got pc/ir/rw/mw=%b want 0000",
                  {PCWre, IRWre, RegWre, mWR});
      end
      Reset = 1'b0;
      #1;
      n_cmp++;
      if (IRWre !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_fetch: got IRWre=%b want 1", IRWre);
      end
   endtask

   task automatic test_add();
      logic [3:0] es [0:4];
      es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
      Op = 6'b000000;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (State !== es[i] || RegWre !== (i == 3) ||
             PCWre !== (i == 3) || IRWre !== (i == 0 || i == 4)) begin
            n_bad++;
            $display("FAIL add_cyc%0d: got st=%0d rw=%b pw=%b ir=%b want st=%0d",
                     i, State, RegWre, PCWre, IRWre, es[i]);
         end
         if (i == 3) begin
            n_cmp++;
            if (RegDst !== 2'b10 || WrRegDSrc !== 1'b1 ||
                DBDataSrc !== 1'b0 || PCSrc !== 2'b00 || ALUOp !== 3'b000) begin
               n_bad++;
               $display("FAIL add_wb: got dst=%b wsrc=%b db=%b pcs=%b alu=%b want 10 1 0 00 000",
                        RegDst, WrRegDSrc, DBDataSrc, PCSrc, ALUOp);
            end
         end
         cyc();
      end
   endtask

   task automatic test_imm();
      logic [5:0] ops [0:2];
      logic [2:0] alu [0:2];
      ops = '{6'b010010, 6'b000010, 6'b100110};
      alu = '{3'b010, 3'b000, 3'b100};
      for (int k = 0; k < 3; k++) begin
         Op = ops[k];
         do_reset();
         cyc();
         cyc();
         n_cmp++;
         if (State !== 4'd2 || ALUOp !== alu[k] ||
             ALUSrcB !== (k < 2) || ExtSel !== (k == 1)) begin
            n_bad++;
            $display("FAIL imm_exe op=%b: got st=%0d alu=%b srcb=%b ext=%b want alu=%b",
                     ops[k], State, ALUOp, ALUSrcB, ExtSel, alu[k]);
         end
         cyc();
         n_cmp++;
         if (State !== 4'd3 || RegDst !== ((k < 2) ? 2'b01 : 2'b10) ||
             ALUOp !== alu[k] || RegWre !== 1'b1) begin
            n_bad++;
            $display("FAIL imm_wb op=%b: got st=%0d dst=%b alu=%b rw=%b",
                     ops[k], State, RegDst, ALUOp, RegWre);
         end
      end
   endtask

   task automatic test_lw();
      logic [3:0] es [0:5];
      es = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd7, 4'd0};
      Op = 6'b110001;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (State !== es[i] || mRD !== (i == 3 || i == 4) ||
             RegWre !== (i == 4) || PCWre !== (i == 4) || mWR !== 1'b0) begin
            n_bad++;
            $display("FAIL lw_cyc%0d: got st=%0d mrd=%b rw=%b pw=%b want st=%0d",
                     i, State, mRD, RegWre, PCWre, es[i]);
         end
         if (i == 2 && (ALUSrcB !== 1'b1 || ExtSel !== 1'b1)) begin
            n_bad++;
            $display("FAIL lw_exe: got srcb=%b ext=%b want 1 1", ALUSrcB, ExtSel);
         end
         if (i == 4) begin
            n_cmp++;
            if (RegDst !== 2'b01 || DBDataSrc !== 1'b1 || WrRegDSrc !== 1'b1) begin
               n_bad++;
               $display("FAIL lw_wb: got dst=%b db=%b wsrc=%b want 01 1 1",
                        RegDst, DBDataSrc, WrRegDSrc);
            end
         end
         cyc();
      end
   endtask

   task automatic test_sw();
      logic [3:0] es [0:4];
      es = '{4'd0, 4'd1, 4'd5, 4'd6, 4'd0};
      Op = 6'b110000;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         n_cmp++;
         if (State !== es[i] || mWR !== (i == 3) || RegWre !== 1'b0 ||
             PCWre !== (i == 3) || mRD !== 1'b0) begin
            n_bad++;
            $display("FAIL sw_cyc%0d: got st=%0d mwr=%b rw=%b pw=%b want st=%0d",
                     i, State, mWR, RegWre, PCWre, es[i]);
         end
         cyc();
      end
   endtask

   task automatic test_beq();
      for (int z = 1; z >= 0; z--) begin
         Op = 6'b110100;
         Zero = z[0];
         do_reset();
         cyc();
         cyc();
         n_cmp++;
         if (State !== 4'd4 || PCSrc !== {1'b0, z[0]} || PCWre !== 1'b1 ||
             ALUOp !== 3'b001 || ExtSel !== 1'b1) begin
            n_bad++;
            $display("FAIL beq_z%0d: got st=%0d pcs=%b pw=%b alu=%b ext=%b want st=4 pcs=0%0d",
                     z, State, PCSrc, PCWre, ALUOp, ExtSel, z);
         end
         cyc();
         n_cmp++;
         if (State !== 4'd0) begin
            n_bad++;
            $display("FAIL beq_len_z%0d: got st=%0d want 0", z, State);
         end
      end
      Zero = 1'b0;
   endtask

   task automatic test_jal();
      Op = 6'b111010;
      do_reset();
      cyc();
      n_cmp++;
      if (State !== 4'd1 || RegWre !== 1'b1 || RegDst !== 2'b00 ||
          WrRegDSrc !== 1'b0 || PCSrc !== 2'b11 || PCWre !== 1'b1) begin
         n_bad++;
         $display("FAIL jal_id: got st=%0d rw=%b dst=%b wsrc=%b pcs=%b pw=%b",
                  State, RegWre, RegDst, WrRegDSrc, PCSrc, PCWre);
      end
      cyc();
      n_cmp++;
      if (State !== 4'd0) begin
         n_bad++;
         $display("FAIL jal_len: got st=%0d want 0", State);
      end
   endtask

   task automatic test_jumps();
      Op = 6'b111001;
      do_reset();
      cyc();
      n_cmp++;
      if (PCSrc !== 2'b10 || PCWre !== 1'b1 || RegWre !== 1'b0) begin
         n_bad++;
         $display("FAIL jr_id: got pcs=%b pw=%b rw=%b want 10 1 0",
                  PCSrc, PCWre, RegWre);
      end
      Op = 6'b111000;
      do_reset();
      cyc();
      n_cmp++;
      if (PCSrc !== 2'b11 || PCWre !== 1'b1 || RegWre !== 1'b0) begin
         n_bad++;
         $display("FAIL j_id: got pcs=%b pw=%b rw=%b want 11 1 0",
                  PCSrc, PCWre, RegWre);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] es [0:8];
      es = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd5, 4'd6, 4'd0};
      Op = 6'b000001;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         if (i == 4) begin
            Op = 6'b110000;
            #1;
         end
         n_cmp++;
         if (State !== es[i]) begin
            n_bad++;
            $display("FAIL b2b_cyc%0d: got st=%0d want %0d", i, State, es[i]);
         end
         cyc();
      end
   endtask

   task automatic test_halt_op();
      Op = 6'b111111;
      do_reset();
      cyc();
      cyc();
      n_cmp++;
      if (State !== 4'd8 || Illegal !== 1'b0) begin
         n_bad++;
         $display("FAIL halt_op: got st=%0d ill=%b want 8 0", State, Illegal);
      end
   endtask

   task automatic test_illegal();
      int bad;
      Op = 6'b101010;
      do_reset();
      cyc();
      n_cmp++;
      if (State !== 4'd1 || Illegal !== 1'b0) begin
         n_bad++;
         $display("FAIL ill_id: got st=%0d ill=%b want 1 0", State, Illegal);
      end
      cyc();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) begin
            Op = 6'b000000;
            #1;
         end
         n_cmp++;
         if (State !== 4'd8 || Illegal !== 1'b1 ||
             {PCWre, IRWre, RegWre, mWR, mRD} !== 5'b00000) begin
            n_bad++;
            $display("FAIL ill_hold%0d: got st=%0d ill=%b en=%b want 8 1 00000",
                     i, State, Illegal, {PCWre, IRWre, RegWre, mWR, mRD});
         end
         cyc();
      end
      Reset = 1'b1;
      #1;
      n_cmp++;
      if ({PCWre, IRWre, RegWre, mWR} !== 4'b0000) begin
         n_bad++;
         $display("FAIL ill_rst_gate: got %b want 0000",
                  {PCWre, IRWre, RegWre, mWR});
      end
      cyc();
      Reset = 1'b0;
      #1;
      n_cmp++;
      if (State !== 4'd0 || Illegal !== 1'b0) begin
         n_bad++;
         $display("FAIL ill_rst: got st=%0d ill=%b want 0 0", State, Illegal);
      end
   endtask

   task automatic test_mid_reset();
      Op = 6'b110000;
      do_reset();
      cyc();
      cyc();
      cyc();
      Reset = 1'b1;
      #1;
      n_cmp++;
      if (State !== 4'd6 || {PCWre, IRWre, RegWre, mWR} !== 4'b0000) begin
         n_bad++;
         $display("FAIL mid_rst_gate: got st=%0d en=%b want 6 0000",
                  State, {PCWre, IRWre, RegWre, mWR});
      end
      cyc();
      Reset = 1'b0;
      #1;
      n_cmp++;
      if (State !== 4'd0 || IRWre !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_rst: got st=%0d ir=%b want 0 1", State, IRWre);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_imm();
      test_lw();
      test_sw();
      test_beq();
      test_jal();
      test_jumps();
      test_back_to_back();
      test_halt_op();
      test_illegal();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
